// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  // Remaining bytes of the 8-byte Pause sequence after its leading E1.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  localparam int KEY_W       = 11;
  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length de-glitch filter.
// The output idles high and follows the input only after FILTER_LEN equal samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: frame deserialiser, idle timeout and
// E0/F0/E1 prefix folding into a toggle-based key event word.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 32768
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ps2_clk_i,
  input  logic              ps2_dat_i,
  output logic [KEY_W-1:0]  key_o,
  output logic [7:0]        byte_o,
  output logic              byte_valid_o,
  output logic              frame_err_o
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic clk_f, dat_f;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_sys (clk_sys),
    .reset   (reset),
    .raw_i   (ps2_clk_i),
    .filt_o  (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk_sys (clk_sys),
    .reset   (reset),
    .raw_i   (ps2_dat_i),
    .filt_o  (dat_f)
  );

  ps2_state_e        state_q, state_d;
  logic              clk_prev_q;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic [2:0]        skip_q, skip_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [7:0]        byte_q, byte_d;
  logic              bvld_q, bvld_d;
  logic              ferr_q, ferr_d;

  logic fall, timeout;

  assign fall    = clk_prev_q & ~clk_f;
  assign timeout = (state_q != IDLE) && (idle_q == IDLE_W'(TIMEOUT_CYC));

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    idle_d   = idle_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    skip_d   = skip_q;
    key_d    = key_q;
    byte_d   = byte_q;
    bvld_d   = 1'b0;
    ferr_d   = 1'b0;

    if (state_q == IDLE || fall) begin
      idle_d = '0;
    end else if (idle_q != IDLE_W'(TIMEOUT_CYC)) begin
      idle_d = idle_q + IDLE_W'(1);
    end

    // A falling edge takes priority over a timeout in the same cycle.
    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!dat_f) begin
            state_d  = DATA;
            bitcnt_d = 4'd0;
          end
        end
        DATA: begin
          shift_d = {dat_f, shift_q[7:1]};
          if (bitcnt_q == 4'd7) begin
            bitcnt_d = 4'd8;
            state_d  = PARITY;
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
        PARITY: begin
          parity_d = dat_f;
          state_d  = STOP;
        end
        STOP: begin
          state_d  = IDLE;
          bitcnt_d = 4'd0;
          if (dat_f && (^{shift_q, parity_q})) begin
            byte_d = shift_q;
            bvld_d = 1'b1;
            if (skip_q != 3'd0) begin
              skip_d = skip_q - 3'd1;
            end else if (shift_q == PFX_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PFX_BRK) begin
              brk_d = 1'b1;
            end else if (shift_q == PFX_PAUSE) begin
              skip_d = PAUSE_SKIP;
            end else begin
              key_d = {~key_q[KEY_TOGGLE], ~brk_q, ext_q, shift_q};
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
          end else begin
            ferr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
            skip_d = 3'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d  = IDLE;
      bitcnt_d = 4'd0;
      shift_d  = 8'd0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      clk_prev_q <= 1'b1;
      bitcnt_q   <= 4'd0;
      shift_q    <= 8'd0;
      parity_q   <= 1'b0;
      idle_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      skip_q     <= 3'd0;
      key_q      <= '0;
      byte_q     <= 8'd0;
      bvld_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_prev_q <= clk_f;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      idle_q     <= idle_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      skip_q     <= skip_d;
      key_q      <= key_d;
      byte_q     <= byte_d;
      bvld_q     <= bvld_d;
      ferr_q     <= ferr_d;
    end
  end

  assign key_o        = key_q;
  assign byte_o       = byte_q;
  assign byte_valid_o = bvld_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed-frame bench with a scoreboard queue of expected byte/error outputs.
module tb_ps2_scancode_rx;

  localparam int FLEN = 8;
  localparam int TMO  = 200;
  localparam int H    = 20;
  localparam int GAP  = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [10:0] key;
  logic [7:0]  byte_out;
  logic        bvld;
  logic        ferr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_err;
    logic [7:0]  b;
    logic [10:0] k;
  } exp_t;

  exp_t exp_q[$];

  ps2_scancode_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYC(TMO)) dut (
    .clk_sys      (clk),
    .reset        (rst),
    .ps2_clk_i    (ps2_clk),
    .ps2_dat_i    (ps2_dat),
    .key_o        (key),
    .byte_o       (byte_out),
    .byte_valid_o (bvld),
    .frame_err_o  (ferr)
  );

  always #5 clk = ~clk;

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every byte_valid or frame_err pulse must match the queue head.
  always @(negedge clk) begin
    if (!rst && (bvld || ferr)) begin
      exp_t e;
      check("bvld_ferr_exclusive", 32'(bvld & ferr), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("kind_is_err", 32'(ferr), 32'(e.is_err));
        if (!e.is_err) check("byte_o", 32'(byte_out), 32'(e.b));
        check("key_o", 32'(key), 32'(e.k));
      end
    end
  end

  task automatic exp_byte(input logic [7:0] b, input logic [10:0] k);
    exp_t e;
    e.is_err = 1'b0; e.b = b; e.k = k;
    exp_q.push_back(e);
  endtask

  task automatic exp_err(input logic [10:0] k);
    exp_t e;
    e.is_err = 1'b1; e.b = 8'h00; e.k = k;
    exp_q.push_back(e);
  endtask

  task automatic ps2_bit(input logic v);
    ps2_dat = v;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par, input logic stop_v, input int nbits);
    logic [10:0] f;
    f = {stop_v, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_dat = 1'b1;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic good(input logic [7:0] b, input logic [10:0] k);
    exp_byte(b, k);
    send(b, 1'b0, 1'b1, 11);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_key_o", 32'(key), 32'h0);
    check("reset_byte_o", 32'(byte_out), 32'h0);
    check("reset_byte_valid_o", 32'(bvld), 32'h0);
    check("reset_frame_err_o", 32'(ferr), 32'h0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    // Plain make, then break.
    good(8'h1C, 11'h61C);
    good(8'hF0, 11'h61C);
    good(8'h1C, 11'h01C);
    // Extended break, then plain make of the same code.
    good(8'hE0, 11'h01C);
    good(8'hF0, 11'h01C);
    good(8'h75, 11'h575);
    good(8'h75, 11'h275);
    // Bad parity, then E0 cancelled by a bad stop bit.
    exp_err(11'h275);
    send(8'h16, 1'b1, 1'b1, 11);
    good(8'hE0, 11'h275);
    exp_err(11'h275);
    send(8'h16, 1'b0, 1'b0, 11);
    good(8'h16, 11'h616);

    // Short low glitch on the clock line while data is low must not start a frame.
    ps2_dat = 1'b0;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (H) @(posedge clk);
    ps2_dat = 1'b1;
    repeat (H) @(posedge clk);
    good(8'h34, 11'h234);

    // Partial frame (start + 3 data bits) abandoned until the idle timeout.
    send(8'h1D, 1'b0, 1'b1, 4);
    repeat (TMO + 20) @(posedge clk);
    good(8'h1D, 11'h61D);

    // Pause sequence produces bytes but no event.
    good(8'hE1, 11'h61D);
    good(8'h14, 11'h61D);
    good(8'h77, 11'h61D);
    good(8'hE1, 11'h61D);
    good(8'hF0, 11'h61D);
    good(8'h14, 11'h61D);
    good(8'hF0, 11'h61D);
    good(8'h77, 11'h61D);
    good(8'h29, 11'h229);

    // Reset mid-frame with a pending E0 prefix.
    good(8'hE0, 11'h229);
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_key_o", 32'(key), 32'h0);
    check("midreset_byte_o", 32'(byte_out), 32'h0);
    check("midreset_byte_valid_o", 32'(bvld), 32'h0);
    check("midreset_frame_err_o", 32'(ferr), 32'h0);
    ps2_dat = 1'b1;
    ps2_clk = 1'b1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    good(8'h5A, 11'h65A);

    repeat (GAP) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

PS/2 keyboard receiver that turns the raw keyboard clock/data pair into the toggle-based key-event word consumed by the console's keyboard-to-controller mapping. It synchronises and de-glitches both lines and deserialises 11-bit device-to-host frames. It folds E0/F0 prefixes into a single event and suppresses the E1 Pause sequence. It sits between the keyboard pins and the button-state decoder.

## Interface
- `FILTER_LEN`, default 8: consecutive equal samples required before a filtered line changes.
- `TIMEOUT_CYC`, default 32768: clk_sys cycles without a falling edge before a partial frame is dropped.
- `clk_sys`  in  1  system clock; only clock in the block.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk_i`  in  1  raw PS/2 clock, asynchronous, idle high.
- `ps2_dat_i`  in  1  raw PS/2 data, asynchronous, idle high.
- `key_o`  out  11  event word {toggle, pressed, extended, code[7:0]}; toggle inverts once per event.
- `byte_o`  out  8  last correctly received raw byte.
- `byte_valid_o`  out  1  one-cycle pulse when byte_o updates.
- `frame_err_o`  out  1  one-cycle pulse on parity or stop-bit error.

## Operation
- Each raw line passes through a 2-FF synchroniser and then a filter counter. The filtered value flips only after FILTER_LEN consecutive samples of the opposite level. The filtered value resets to 1.
- A falling edge is filtered clk going 1→0. Data is sampled on that cycle.
- Frame FSM:
  - IDLE: sampled 0 → DATA with bit count 0. Sampled 1 → stay in IDLE, no error.
  - DATA: shift the bit in LSB first. After 8 bits → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: accept the frame only if the stop bit is 1 and data plus parity have odd weight. Otherwise pulse frame_err_o. Then → IDLE.
- Timeout: in any state except IDLE, the idle counter reaching TIMEOUT_CYC returns the FSM to IDLE and discards the partial byte. No error pulse. The counter clears on every falling edge.
- Prefix assembler, run on each accepted byte:
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - 0xE1 loads skip=7. The next 7 accepted bytes are dropped, with no event and no flag changes.
  - Any other byte emits an event: code=byte, extended=ext, pressed=~brk, toggle inverted. Then ext and brk clear.
- A frame error clears ext, brk and skip.
- byte_valid_o pulses for every accepted byte, including prefix and skipped bytes.
- key_o holds its value between events.

## Timing
- Reset values:
  - key_o=0, byte_o=0, byte_valid_o=0, frame_err_o=0.
  - FSM=IDLE, all counters 0, ext, brk and skip cleared, filtered lines=1.
- A reset mid-frame discards the frame and any pending prefix.
- Filter latency is 2 synchroniser cycles plus FILTER_LEN cycles from a raw edge to the filtered edge.
- byte_o, byte_valid_o, frame_err_o and key_o all update in the cycle after the filtered falling edge that samples the stop bit, i.e. they are registered.
- An event and byte_valid_o coincide in the same cycle. frame_err_o and byte_valid_o are never high together.
- No back-pressure. Bytes are at least ~60 µs apart, so at most one event is issued per frame.
- Bit count is 4 bits and saturates at 8. The idle counter is $clog2(TIMEOUT_CYC+1) bits wide and saturates.
- Simultaneous timeout and falling edge in the same cycle: the edge wins and is processed. The counter clears.

## Structure
- Package `ps2_pkg`:
  - FSM state enum {IDLE, DATA, PARITY, STOP}.
  - Constants PFX_EXT=8'hE0, PFX_BRK=8'hF0, PFX_PAUSE=8'hE1.
  - key_o field positions: KEY_TOGGLE=10, KEY_PRESSED=9, KEY_EXT=8.
- Sub-module `ps2_line_filter` (synchroniser plus filter counter, parameter FILTER_LEN, reset value 1), instantiated for clk and data.
- The FSM, timeout and prefix assembler live in the top module.

## Test plan
- Frame 0x1C, parity 0, stop 1, from reset → byte_valid_o pulse, byte_o=0x1C, key_o=11'b1_1_0_00011100.
- Then F0,1C → two byte_valid_o pulses, one event only: key_o=11'b0_0_0_00011100.
- E0,F0,75 → one event: toggle flips, pressed=0, extended=1, code=0x75. A following 0x75 gives extended=0 and pressed=1.
- 0x16 with parity bit 1 → frame_err_o pulse, no byte_valid_o, key_o unchanged. Then E0 followed by a bad frame and then 0x16 → extended=0.
- Glitch: 3-cycle low pulse on ps2_clk_i with FILTER_LEN=8 → no bit shifted. Frame aborted after 4 bits plus TIMEOUT_CYC idle cycles → back to IDLE, and a following good 0x1D frame decodes as 0x1D.
- Pause sequence E1,14,77,E1,F0,14,F0,77 → 8 byte_valid_o pulses, no toggle. A following 0x29 → event code=0x29, pressed=1. Also: assert reset mid-DATA → outputs 0, and the next full frame decodes correctly.
